// File: rtl/fsm_par_tx.sv
// Packet transmitter: frames payload bytes with header and rolling sequence nibbles
// and drives them onto a 16-bit valid/ready bus, with per-frame error injection.
module fsm_par_tx #(
    parameter int unsigned          BUS_SIZE  = 16,
    parameter int unsigned          WORD_SIZE = 4,
    parameter logic [WORD_SIZE-1:0] HEADER    = 'hF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [BUS_SIZE-2*WORD_SIZE-1:0]   payload_in,
    input  logic                              payload_valid,
    output logic                              payload_ready,
    input  logic                              inj_seq_err,
    input  logic                              inj_pkg_err,
    output logic [BUS_SIZE-1:0]               bus_data_out,
    output logic                              bus_valid,
    input  logic                              bus_ready,
    output logic [WORD_SIZE-1:0]              seq_cnt,
    output logic [1:0]                        state,
    output logic [7:0]                        frame_cnt
);

    localparam int unsigned WORD_NUM = BUS_SIZE / WORD_SIZE;
    localparam int unsigned PAY_W    = (WORD_NUM - 2) * WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        SEND = 2'b10
    } state_e;

    state_e               state_q;
    logic [BUS_SIZE-1:0]  bus_data_q;
    logic                 bus_valid_q;
    logic [WORD_SIZE-1:0] seq_q;
    logic [7:0]           frame_cnt_q;

    logic [WORD_SIZE-1:0] hdr_d;
    logic [WORD_SIZE-1:0] seq_field_d;
    logic [PAY_W-1:0]     payload_d;
    logic [BUS_SIZE-1:0]  frame_d;
    logic                 xfer;
    logic                 take;

    // In SEND a new byte is only accepted when the current frame leaves this cycle.
    assign payload_ready = !reset && enable && ((state_q == IDLE) || bus_ready);
    assign xfer          = payload_valid && payload_ready;
    assign take          = bus_valid_q && bus_ready;

    // Frame assembly, including the optional header/sequence corruption.
    always_comb begin
        hdr_d       = HEADER;
        seq_field_d = seq_q;
        payload_d   = payload_in;
        if (inj_pkg_err) hdr_d = ~HEADER;
        if (inj_seq_err) seq_field_d = seq_q + WORD_SIZE'(1);
        frame_d     = {hdr_d, payload_d, seq_field_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
            seq_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (take && (frame_cnt_q != 8'hFF)) frame_cnt_q <= frame_cnt_q + 8'd1;

            // A transfer always refills the frame register; otherwise a take empties it.
            if (xfer) begin
                bus_data_q  <= frame_d;
                bus_valid_q <= 1'b1;
                state_q     <= SEND;
                seq_q       <= seq_q + WORD_SIZE'(1);
            end else if ((state_q == SEND) && bus_ready) begin
                bus_valid_q <= 1'b0;
                state_q     <= IDLE;
            end
        end
    end

    assign bus_data_out = bus_data_q;
    assign bus_valid    = bus_valid_q;
    assign seq_cnt      = seq_q;
    assign state        = state_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
